// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-table builder and reader:
// default table geometry and the reader FSM state encoding.
package freq_pkg;

    localparam int unsigned FREQ_TABLE_SIZE  = 256;
    localparam int unsigned FREQ_DATA_WIDTH  = 8;
    localparam int unsigned FREQ_COUNT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } freq_state_e;

endpackage

// File: rtl/freq_table_reader.sv
// Walks a histogram in ascending symbol order and streams out every nonzero
// (symbol, count) pair over a valid/ready handshake, totalling as it goes.
module freq_table_reader
    import freq_pkg::*;
#(
    parameter int unsigned TABLE_SIZE  = FREQ_TABLE_SIZE,
    parameter int unsigned DATA_WIDTH  = FREQ_DATA_WIDTH,
    parameter int unsigned COUNT_WIDTH = FREQ_COUNT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_in,
    input  logic [COUNT_WIDTH-1:0]          freq_table [TABLE_SIZE],
    input  logic                            start_in,
    output logic [DATA_WIDTH-1:0]           sym_out,
    output logic [COUNT_WIDTH-1:0]          count_out,
    output logic                            valid_out,
    input  logic                            ready_in,
    output logic                            busy_out,
    output logic                            done_out,
    output logic [DATA_WIDTH:0]             num_symbols_out,
    output logic [COUNT_WIDTH+DATA_WIDTH-1:0] total_out
);

    localparam int unsigned TOTAL_W = COUNT_WIDTH + DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(TABLE_SIZE - 1);

    freq_state_e             state;
    logic [DATA_WIDTH-1:0]   idx;
    logic [COUNT_WIDTH-1:0]  entry;
    logic                    at_last;

    assign entry   = freq_table[idx];
    assign at_last = (idx == LAST_IDX);

    // done_out is raised on the edge entering DONE, so it coincides with the
    // single DONE cycle and with the last cycle of busy_out.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state           <= ST_IDLE;
            idx             <= '0;
            sym_out         <= '0;
            count_out       <= '0;
            valid_out       <= 1'b0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            num_symbols_out <= '0;
            total_out       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        idx             <= '0;
                        num_symbols_out <= '0;
                        total_out       <= '0;
                        busy_out        <= 1'b1;
                        state           <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (entry != '0) begin
                        sym_out   <= idx;
                        count_out <= entry;
                        valid_out <= 1'b1;
                        state     <= ST_EMIT;
                    end else if (at_last) begin
                        done_out <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        idx <= idx + DATA_WIDTH'(1);
                    end
                end
                ST_EMIT: begin
                    if (valid_out && ready_in) begin
                        valid_out       <= 1'b0;
                        num_symbols_out <= num_symbols_out + (DATA_WIDTH+1)'(1);
                        total_out       <= total_out + TOTAL_W'(count_out);
                        if (at_last) begin
                            done_out <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            idx   <= idx + DATA_WIDTH'(1);
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_table_reader.sv
// Self-checking bench for freq_table_reader: directed vector table, random
// tables against a queue-based reference, and reset/backpressure sequences.
module tb_freq_table_reader;

    localparam int TS = 256;
    localparam int DW = 8;
    localparam int CW = 32;

    logic              clk;
    logic              rst_in;
    logic [CW-1:0]     tbl [TS];
    logic              start_in;
    logic [DW-1:0]     sym_out;
    logic [CW-1:0]     count_out;
    logic              valid_out;
    logic              ready_in;
    logic              busy_out;
    logic              done_out;
    logic [DW:0]       num_symbols_out;
    logic [CW+DW-1:0]  total_out;

    int checks   = 0;
    int failures = 0;

    freq_table_reader #(.TABLE_SIZE(TS), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst_in          (rst_in),
        .freq_table      (tbl),
        .start_in        (start_in),
        .sym_out         (sym_out),
        .count_out       (count_out),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .num_symbols_out (num_symbols_out),
        .total_out       (total_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          s0; logic [CW-1:0] c0;
        int          s1; logic [CW-1:0] c1;
        int          s2; logic [CW-1:0] c2;
        int          ready_pct;
        int          stall;
        int          exp_num;
        longint      exp_total;
    } vec_t;

    vec_t vecs [6];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic clear_table();
        for (int i = 0; i < TS; i++) tbl[i] = '0;
    endtask

    // Runs one complete scan of the current table and checks the pair stream,
    // handshake stability, done timing and the final totals against a model.
    task automatic do_scan(input string tag, input int ready_pct, input int stall_first,
                           input int start_at, input bit check_exp,
                           input int exp_num, input longint exp_total);
        logic [DW-1:0]   q_sym [$];
        logic [CW-1:0]   q_cnt [$];
        int              m_num;
        longint unsigned m_total;
        int              n, vcycles, stall;
        bit              seen_done, prev_hold;
        logic [DW-1:0]   prev_sym;
        logic [CW-1:0]   prev_cnt;

        m_num = 0; m_total = 0;
        for (int i = 0; i < TS; i++) begin
            if (tbl[i] != 0) begin
                q_sym.push_back(DW'(i));
                q_cnt.push_back(tbl[i]);
                m_num++;
                m_total += longint'(tbl[i]);
            end
        end

        @(negedge clk);
        start_in = 1'b1;
        ready_in = 1'($urandom_range(1));
        n = 0; vcycles = 0; seen_done = 0; prev_hold = 0; stall = stall_first;
        prev_sym = '0; prev_cnt = '0;

        while (!seen_done && n < 6000) begin
            @(negedge clk);
            start_in = 1'b0;
            n++;
            if (n == 1) check({tag, "/busy_after_start"}, 64'(busy_out), 64'd1);
            if (n == start_at) start_in = 1'b1;
            if (prev_hold) begin
                check({tag, "/hold_valid"}, 64'(valid_out), 64'd1);
                check({tag, "/hold_sym"},   64'(sym_out),   64'(prev_sym));
                check({tag, "/hold_count"}, 64'(count_out), 64'(prev_cnt));
            end
            if (done_out) begin
                seen_done = 1;
                check({tag, "/done_latency"}, 64'(n), 64'(257 + vcycles));
                check({tag, "/pairs_left"},   64'(q_sym.size()), 64'd0);
                check({tag, "/num_symbols"},  64'(num_symbols_out), 64'(m_num));
                check({tag, "/total"},        64'(total_out), 64'(m_total));
                if (check_exp) begin
                    check({tag, "/num_expected"},   64'(num_symbols_out), 64'(exp_num));
                    check({tag, "/total_expected"}, 64'(total_out), 64'(exp_total));
                end
                start_in  = 1'b1;
                prev_hold = 0;
            end else if (valid_out) begin
                vcycles++;
                if (stall > 0) begin
                    ready_in = 1'b0;
                    stall--;
                end else begin
                    ready_in = ($urandom_range(99) < 32'(ready_pct));
                end
                if (ready_in) begin
                    if (q_sym.size() == 0) begin
                        check({tag, "/unexpected_pair"}, 64'd1, 64'd0);
                    end else begin
                        check({tag, "/pair_sym"},   64'(sym_out),   64'(q_sym.pop_front()));
                        check({tag, "/pair_count"}, 64'(count_out), 64'(q_cnt.pop_front()));
                    end
                end
                prev_hold = !ready_in;
                prev_sym  = sym_out;
                prev_cnt  = count_out;
            end else begin
                ready_in  = 1'($urandom_range(1));
                prev_hold = 0;
            end
        end

        if (!seen_done) begin
            check({tag, "/done_timeout"}, 64'd0, 64'd1);
        end else begin
            @(negedge clk);
            start_in = 1'b0;
            check({tag, "/done_one_cycle"}, 64'(done_out), 64'd0);
            check({tag, "/idle_after_done"}, 64'(busy_out), 64'd0);
            repeat (3) @(negedge clk);
            check({tag, "/still_idle"}, 64'(busy_out), 64'd0);
            check({tag, "/num_held"},   64'(num_symbols_out), 64'(m_num));
            check({tag, "/total_held"}, 64'(total_out), 64'(m_total));
        end
        ready_in = 1'b0;
    endtask

    initial begin
        int hit;

        vecs[0] = '{-1, 32'd0, -1, 32'd0, -1, 32'd0, 100, 0, 0, 64'd0};
        vecs[1] = '{3, 32'd5, 200, 32'd1, 255, 32'd7, 100, 0, 3, 64'd13};
        vecs[2] = '{10, 32'd9, -1, 32'd0, -1, 32'd0, 100, 4, 1, 64'd9};
        vecs[3] = '{0, 32'd1, 1, 32'd2, 2, 32'd3, 50, 2, 3, 64'd6};
        vecs[4] = '{255, 32'hFFFF_FFFF, -1, 32'd0, -1, 32'd0, 30, 1, 1, 64'hFFFF_FFFF};
        vecs[5] = '{0, 32'h8000_0000, 254, 32'h8000_0000, -1, 32'd0, 70, 0, 2, 64'h1_0000_0000};

        rst_in = 1'b0; start_in = 1'b0; ready_in = 1'b0;
        clear_table();
        repeat (2) @(negedge clk);
        check("reset/valid", 64'(valid_out), 64'd0);
        check("reset/busy",  64'(busy_out),  64'd0);
        check("reset/done",  64'(done_out),  64'd0);
        check("reset/sym",   64'(sym_out),   64'd0);
        check("reset/count", 64'(count_out), 64'd0);
        check("reset/num",   64'(num_symbols_out), 64'd0);
        check("reset/total", 64'(total_out), 64'd0);
        rst_in = 1'b1;

        for (int v = 0; v < 6; v++) begin
            clear_table();
            if (vecs[v].s0 >= 0) tbl[vecs[v].s0] = vecs[v].c0;
            if (vecs[v].s1 >= 0) tbl[vecs[v].s1] = vecs[v].c1;
            if (vecs[v].s2 >= 0) tbl[vecs[v].s2] = vecs[v].c2;
            do_scan($sformatf("vec%0d", v), vecs[v].ready_pct, vecs[v].stall, 0, 1,
                    vecs[v].exp_num, vecs[v].exp_total);
        end

        for (int i = 0; i < TS; i++) tbl[i] = 32'hFFFF_FFFF;
        do_scan("all_ones", 100, 0, 0, 1, 256, 64'hFF_FFFF_FF00);

        clear_table();
        tbl[5] = 32'd4; tbl[6] = 32'd8; tbl[100] = 32'd2;
        do_scan("midscan_start", 100, 0, 50, 1, 3, 64'd14);

        for (int r = 0; r < 6; r++) begin
            int dens;
            dens = int'($urandom_range(0, 100));
            for (int i = 0; i < TS; i++)
                tbl[i] = ($urandom_range(99) < 32'(dens)) ?
                         (($urandom_range(1) != 0) ? $urandom : CW'($urandom_range(1, 20))) : '0;
            do_scan($sformatf("rand%0d", r), int'($urandom_range(25, 100)), 0,
                    int'($urandom_range(2, 200)), 0, 0, 64'd0);
        end

        clear_table();
        tbl[10] = 32'd9; tbl[20] = 32'd3;
        @(negedge clk);
        start_in = 1'b1; ready_in = 1'b0;
        @(negedge clk);
        start_in = 1'b0;
        hit = 0;
        for (int k = 0; k < 50 && hit == 0; k++) begin
            if (valid_out) hit = 1;
            else @(negedge clk);
        end
        check("rst_emit/valid_seen", 64'(hit), 64'd1);
        #2 rst_in = 1'b0;
        #1;
        check("rst_emit/valid_async", 64'(valid_out), 64'd0);
        check("rst_emit/busy",  64'(busy_out),  64'd0);
        check("rst_emit/sym",   64'(sym_out),   64'd0);
        check("rst_emit/count", 64'(count_out), 64'd0);
        check("rst_emit/done",  64'(done_out),  64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_emit/no_done", 64'(done_out), 64'd0);
        end
        rst_in = 1'b1;
        do_scan("post_reset", 100, 0, 0, 1, 2, 64'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_table_reader.md
FREQ_TABLE_READER -- requirements
Module: freq_table_reader

Interface
REQ-001 SHALL have parameter TABLE_SIZE, default 256: number of table entries, one per pixel value.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: symbol width, with TABLE_SIZE = 2**DATA_WIDTH.
REQ-003 SHALL have parameter COUNT_WIDTH, default 32: width of each table entry.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_in  input  1  asynchronous active-low reset.
REQ-006 SHALL have port freq_table  input  COUNT_WIDTH x TABLE_SIZE (unpacked)  histogram to read.
REQ-007 SHALL have port start_in  input  1  single-cycle request to begin a scan.
REQ-008 SHALL have port sym_out  output  DATA_WIDTH  symbol (table index) of the current pair.
REQ-009 SHALL have port count_out  output  COUNT_WIDTH  frequency of sym_out.
REQ-010 SHALL have port valid_out  output  1  sym_out/count_out pair valid.
REQ-011 SHALL have port ready_in  input  1  downstream accepts the pair.
REQ-012 SHALL have port busy_out  output  1  high from the cycle after an accepted start until DONE exits.
REQ-013 SHALL have port done_out  output  1  one-cycle pulse at end of scan.
REQ-014 SHALL have port num_symbols_out  output  DATA_WIDTH+1  count of nonzero entries emitted.
REQ-015 SHALL have port total_out  output  COUNT_WIDTH+DATA_WIDTH  sum of emitted counts.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, EMIT, DONE; reset state IDLE.
REQ-017 SHALL, in IDLE on start_in=1, clear idx, num_symbols_out and total_out, then enter SCAN next cycle.
REQ-018 SHALL, in SCAN, examine freq_table[idx] once per cycle.
REQ-019 SHALL, in SCAN with a zero entry, go to DONE if idx==TABLE_SIZE-1, else increment idx and stay in SCAN.
REQ-020 SHALL, in SCAN with a nonzero entry, register sym_out=idx and count_out=entry, set valid_out=1, and enter EMIT; valid_out rises one cycle after the SCAN cycle.
REQ-021 SHALL, in EMIT, hold sym_out, count_out and valid_out stable until valid_out && ready_in.
REQ-022 SHALL, on each handshake, add 1 to num_symbols_out, add count_out to total_out, and clear valid_out the next cycle.
REQ-023 SHALL, after a handshake, go to DONE if idx==TABLE_SIZE-1; otherwise increment idx and return to SCAN.
REQ-024 SHALL, in DONE, assert done_out for exactly one cycle and return to IDLE.
REQ-025 SHALL hold num_symbols_out and total_out after DONE until the next accepted start.
REQ-026 SHALL ignore start_in outside IDLE, including start_in asserted during DONE.
REQ-027 SHALL treat ready_in as don't-care when valid_out=0.
REQ-028 SHALL hold idx wrap-free: idx never increments past TABLE_SIZE-1.
REQ-029 SHALL carry no overflow in total_out, since its COUNT_WIDTH+DATA_WIDTH width covers the maximum sum.
REQ-030 SHALL sample freq_table only in SCAN; the caller holds the table stable while busy_out=1.
REQ-031 SHALL emit pairs in strictly ascending symbol order and skip zero entries.

Reset
REQ-032 SHALL, on rst_in=0, immediately force state IDLE, idx=0, valid_out=0, done_out=0, busy_out=0, sym_out=0, count_out=0, num_symbols_out=0, total_out=0.
REQ-033 SHALL, when rst_in asserts mid-scan, abort the scan with no done_out pulse; rst_in is synchronously deasserted.

Structure
REQ-034 SHALL place the FSM state enum and the default TABLE_SIZE/DATA_WIDTH/COUNT_WIDTH constants in a shared package, freq_pkg, shared with the frequency-table builder.
REQ-035 SHALL be a single module with no sub-modules; the entry mux is freq_table[idx].

Verification
REQ-036 SHALL cover an all-zero table with ready_in=1: start -> no valid_out, done_out 257 cycles after start, num_symbols_out=0, total_out=0.
REQ-037 SHALL cover entries [3]=5, [200]=1, [255]=7 with ready_in=1: pairs (3,5), (200,1), (255,7) in order, then done_out; num_symbols_out=3, total_out=13.
REQ-038 SHALL cover backpressure with entry [10]=9 and ready_in low for 4 cycles: valid_out, sym_out=10 and count_out=9 are held stable; exactly one transfer occurs.
REQ-039 SHALL cover an all-entries table with every entry 32'hFFFF_FFFF: 256 pairs, num_symbols_out=256, total_out=40'hFF_FFFF_FF00.
REQ-040 SHALL cover start_in pulsed mid-scan: it is ignored and the output sequence is unchanged.
REQ-041 SHALL cover rst_in low while in EMIT: valid_out drops asynchronously, no done_out pulse, and a fresh start then completes correctly.
